// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared pixel type, constants and serializer state
package ws2812b_pkg;

    localparam int BITS_PER_PIXEL = 24;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic {
        SER_EMPTY = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ws2812b_pixel_feeder_if.sv
// rtl/ws2812b_pixel_feeder_if.sv - pixel handshake and bit stream bundle
interface ws2812b_pixel_feeder_if;
    import ws2812b_pkg::*;

    logic   pix_valid;
    pixel_t pix_data;
    logic   pix_ready;
    logic   bit_valid;
    logic   bit_data;
    logic   frame_last;
    logic   bit_take;

    modport master (
        output pix_valid, pix_data, bit_take,
        input  pix_ready, bit_valid, bit_data, frame_last
    );

    modport slave (
        input  pix_valid, pix_data, bit_take,
        output pix_ready, bit_valid, bit_data, frame_last
    );

endinterface

// File: rtl/ws2812b_pixel_fifo.sv
// rtl/ws2812b_pixel_fifo.sv - pixel FIFO with wrap-bit pointers
module ws2812b_pixel_fifo
    import ws2812b_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   res,
    input  logic   push,
    input  pixel_t push_data,
    input  logic   pop,
    output pixel_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    pixel_t      mem [DEPTH];

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push into a full FIFO and a pop from an empty one are dropped
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ws2812b_pixel_feeder.sv
// rtl/ws2812b_pixel_feeder.sv - buffers GRB pixels and serializes them MSB-first per frame
module ws2812b_pixel_feeder
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    res,
    ws2812b_pixel_feeder_if.slave   px,
    output logic                    frame_done,
    output logic                    underrun
);

    localparam int            PW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_LEDS - 1);
    localparam logic [4:0]    LAST_BIT = 5'(BITS_PER_PIXEL - 1);

    ser_state_t    state, state_nx;
    logic [23:0]   shift_q, shift_nx;
    logic [4:0]    bit_cnt, bit_cnt_nx;
    logic [PW-1:0] pix_cnt, pix_cnt_nx;
    logic          frame_done_nx, underrun_nx;
    logic          fifo_pop, fifo_full, fifo_empty;
    pixel_t        fifo_data;
    logic          last_bit;

    ws2812b_pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .res       (res),
        .push      (px.pix_valid),
        .push_data (px.pix_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign last_bit      = (state == SER_SHIFT) && (bit_cnt == LAST_BIT);
    assign px.pix_ready  = !fifo_full;
    assign px.bit_valid  = (state == SER_SHIFT);
    assign px.bit_data   = (state == SER_SHIFT) && shift_q[23];
    assign px.frame_last = last_bit && (pix_cnt == LAST_PIX);

    // Serializer next state: load from FIFO, shift on take, reload with no bubble at pixel end
    always_comb begin
        state_nx      = state;
        shift_nx      = shift_q;
        bit_cnt_nx    = bit_cnt;
        pix_cnt_nx    = pix_cnt;
        fifo_pop      = 1'b0;
        frame_done_nx = 1'b0;
        underrun_nx   = 1'b0;
        case (state)
            SER_EMPTY: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_nx   = fifo_data;
                    bit_cnt_nx = '0;
                    state_nx   = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (px.bit_take) begin
                    if (!last_bit) begin
                        shift_nx   = {shift_q[22:0], 1'b0};
                        bit_cnt_nx = bit_cnt + 5'd1;
                    end else begin
                        pix_cnt_nx    = (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
                        frame_done_nx = (pix_cnt == LAST_PIX);
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            shift_nx   = fifo_data;
                            bit_cnt_nx = '0;
                        end else begin
                            state_nx    = SER_EMPTY;
                            underrun_nx = (pix_cnt != LAST_PIX);
                        end
                    end
                end
            end
            default: state_nx = SER_EMPTY;
        endcase
    end

    // Serializer, position counters and status pulses
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= SER_EMPTY;
            shift_q    <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_q    <= shift_nx;
            bit_cnt    <= bit_cnt_nx;
            pix_cnt    <= pix_cnt_nx;
            frame_done <= frame_done_nx;
            underrun   <= underrun_nx;
        end
    end

endmodule
